// File: rtl/distribute_arbiter_if.sv
// -----------------------------------------------------------------------------
// distribute_arbiter_if
//   Bundles the requester, distributor and routing signals of the
//   distribute_arbiter so the arbiter and its neighbours connect through one
//   port.
//
//   Parameters
//     C_IN_BYTES  - width in bytes of each requester's FWFT word
//     C_LEN_WIDTH - width of a transfer length (in input words)
//
//   Signal groups
//     REQx / LENx / GNTx / DONEx        - per-requester arbitration handshake
//     INx_EN / INx_DATA / INx_RD_EN     - per-requester FWFT read port
//     DIST_INDATA_EN / DIST_INDATA /
//     DIST_INDATA_RD_EN                 - word stream into the distributor
//     DIST_FLUSH / DIST_FLUSHED         - end-of-transfer flush handshake
//     OUT_SEL                           - granted requester index
//
//   Modports
//     master - the arbiter itself
//     slave  - the requesters + distributor side (directions mirrored)
// -----------------------------------------------------------------------------
interface distribute_arbiter_if #(
    parameter int C_IN_BYTES  = 4,
    parameter int C_LEN_WIDTH = 16
);
    // Arbitration handshake
    logic                     REQ0;
    logic                     REQ1;
    logic [C_LEN_WIDTH-1:0]   LEN0;
    logic [C_LEN_WIDTH-1:0]   LEN1;
    logic                     GNT0;
    logic                     GNT1;
    logic                     DONE0;
    logic                     DONE1;

    // Requester FWFT ports
    logic                     IN0_EN;
    logic                     IN1_EN;
    logic [8*C_IN_BYTES-1:0]  IN0_DATA;
    logic [8*C_IN_BYTES-1:0]  IN1_DATA;
    logic                     IN0_RD_EN;
    logic                     IN1_RD_EN;

    // Distributor side
    logic                     DIST_INDATA_EN;
    logic [8*C_IN_BYTES-1:0]  DIST_INDATA;
    logic                     DIST_INDATA_RD_EN;
    logic                     DIST_FLUSH;
    logic                     DIST_FLUSHED;

    // Output routing
    logic                     OUT_SEL;

    modport master (
        input  REQ0, REQ1, LEN0, LEN1,
        input  IN0_EN, IN1_EN, IN0_DATA, IN1_DATA,
        input  DIST_INDATA_RD_EN, DIST_FLUSHED,
        output GNT0, GNT1, DONE0, DONE1,
        output IN0_RD_EN, IN1_RD_EN,
        output DIST_INDATA_EN, DIST_INDATA, DIST_FLUSH,
        output OUT_SEL
    );

    modport slave (
        output REQ0, REQ1, LEN0, LEN1,
        output IN0_EN, IN1_EN, IN0_DATA, IN1_DATA,
        output DIST_INDATA_RD_EN, DIST_FLUSHED,
        input  GNT0, GNT1, DONE0, DONE1,
        input  IN0_RD_EN, IN1_RD_EN,
        input  DIST_INDATA_EN, DIST_INDATA, DIST_FLUSH,
        input  OUT_SEL
    );

endinterface : distribute_arbiter_if

// File: rtl/distribute_arbiter.sv
// -----------------------------------------------------------------------------
// distribute_arbiter
//   Shares one distributor between two FWFT requesters.  A requester raises
//   REQx with a word count on LENx; the arbiter grants one requester
//   (round-robin when both ask), streams exactly LENx words from that
//   requester's FWFT into the distributor, pulses DIST_FLUSH, waits for
//   DIST_FLUSHED and finally pulses DONEx.
//
//   Ports
//     CLK   - clock, all state changes on the rising edge
//     RST_N - asynchronous active-low reset
//     bus   - distribute_arbiter_if.master (handshake, FWFT and distributor
//             signals, see the interface file)
//
//   Parameters
//     C_IN_BYTES  - FWFT word width in bytes (must match the interface)
//     C_LEN_WIDTH - transfer length width (must match the interface)
// -----------------------------------------------------------------------------
module distribute_arbiter #(
    parameter int C_IN_BYTES  = 4,
    parameter int C_LEN_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    distribute_arbiter_if.master        bus
);

    localparam int DATA_W = 8 * C_IN_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XFER  = 3'd1,
        FLUSH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_reg, state_next;
    logic                    sel_reg, sel_next;       // granted requester
    logic                    last_reg, last_next;     // last requester served
    logic [C_LEN_WIDTH-1:0]  remaining_reg, remaining_next;

    // -------------------------------------------------------------------------
    // Per-requester views of the bus so the datapath can be indexed by sel_reg
    // -------------------------------------------------------------------------
    logic [1:0]              req_vec;
    logic [1:0]              in_en_vec;
    logic [C_LEN_WIDTH-1:0]  len_arr     [2];
    logic [DATA_W-1:0]       in_data_arr [2];

    logic [1:0]              gnt_vec;
    logic [1:0]              done_vec;
    logic [1:0]              rd_en_vec;

    assign req_vec        = {bus.REQ1, bus.REQ0};
    assign in_en_vec      = {bus.IN1_EN, bus.IN0_EN};
    assign len_arr[0]     = bus.LEN0;
    assign len_arr[1]     = bus.LEN1;
    assign in_data_arr[0] = bus.IN0_DATA;
    assign in_data_arr[1] = bus.IN1_DATA;

    // -------------------------------------------------------------------------
    // Decoded state
    // -------------------------------------------------------------------------
    logic active;      // a requester owns the distributor (XFER..DONE)
    logic in_xfer;
    logic sel_in_en;   // granted requester's FWFT has a word
    logic rd_valid;    // a word actually moves this cycle

    assign active    = (state_reg != IDLE);
    assign in_xfer   = (state_reg == XFER);
    assign sel_in_en = in_en_vec[sel_reg];
    assign rd_valid  = in_xfer && bus.DIST_INDATA_RD_EN && sel_in_en;

    // -------------------------------------------------------------------------
    // Requester selection in IDLE.  With both requesting, the one not served
    // last wins; last_reg resets to 1 so requester 0 wins the first contest.
    // -------------------------------------------------------------------------
    logic pick;

    always_comb begin
        pick = 1'b0;
        if (req_vec == 2'b11) begin
            pick = ~last_reg;
        end else begin
            pick = req_vec[1];
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            sel_reg       <= 1'b0;
            last_reg      <= 1'b1;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
            remaining_reg <= remaining_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.  Grant and length are only captured in IDLE, so REQ
    // and LEN activity during a transfer has no effect on it.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        remaining_next = remaining_reg;

        unique case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    sel_next       = pick;
                    remaining_next = len_arr[pick];
                    // A zero-length request skips straight to the flush.
                    if (len_arr[pick] == '0) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = XFER;
                    end
                end
            end

            XFER: begin
                // Only a read of a valid word counts against the length.
                if (rd_valid) begin
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == C_LEN_WIDTH'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end

            FLUSH: begin
                state_next = WAIT;
            end

            WAIT: begin
                if (bus.DIST_FLUSHED) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                last_next  = sel_reg;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-requester outputs.  All are decoded from registered state, so the
    // asynchronous reset forces them low immediately.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic is_sel;
            assign is_sel        = (sel_reg == 1'(gi));
            assign gnt_vec[gi]   = active && is_sel;
            assign done_vec[gi]  = (state_reg == DONE) && is_sel;
            // The FWFT read strobe follows the distributor's consume strobe
            // for the granted requester only.
            assign rd_en_vec[gi] = in_xfer && is_sel && bus.DIST_INDATA_RD_EN;
        end
    endgenerate

    assign bus.GNT0      = gnt_vec[0];
    assign bus.GNT1      = gnt_vec[1];
    assign bus.DONE0     = done_vec[0];
    assign bus.DONE1     = done_vec[1];
    assign bus.IN0_RD_EN = rd_en_vec[0];
    assign bus.IN1_RD_EN = rd_en_vec[1];

    // -------------------------------------------------------------------------
    // Distributor-side outputs
    // -------------------------------------------------------------------------
    assign bus.DIST_INDATA_EN = in_xfer && sel_in_en;
    assign bus.DIST_INDATA    = in_xfer ? in_data_arr[sel_reg] : '0;
    assign bus.DIST_FLUSH     = (state_reg == FLUSH);
    assign bus.OUT_SEL        = active && sel_reg;

endmodule : distribute_arbiter

// File: tb/tb_distribute_arbiter.sv
// -----------------------------------------------------------------------------
// tb_distribute_arbiter
//   Directed bench for distribute_arbiter: reset state, single transfer with a
//   slow distributor, round-robin contest, zero-length transfer, FWFT valid
//   gaps, reset during WAIT and a long WAIT.
// -----------------------------------------------------------------------------
module tb_distribute_arbiter;

    localparam int C_IN_BYTES  = 4;
    localparam int C_LEN_WIDTH = 16;

    logic CLK;
    logic RST_N;

    distribute_arbiter_if #(
        .C_IN_BYTES (C_IN_BYTES),
        .C_LEN_WIDTH(C_LEN_WIDTH)
    ) bus ();

    distribute_arbiter #(
        .C_IN_BYTES (C_IN_BYTES),
        .C_LEN_WIDTH(C_LEN_WIDTH)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Statistics gathered by run_xfer
    int cyc, first_gnt, gnt0_first, gnt1_first;
    int rd0_cnt, rd1_cnt, last_rd, flush_cnt, flush_cyc, fl_rise;
    int done_cyc, done_who, data_err, sel_err;

    // Runs one transfer to completion. The distributor consumes on every
    // rd_period-th cycle and reports drained fl_delay cycles after the flush.
    task automatic run_xfer(input logic exp_sel, input int rd_period, input int fl_delay);
        logic [31:0] exp_data;
        cyc = 0; first_gnt = -1; gnt0_first = -1; gnt1_first = -1;
        rd0_cnt = 0; rd1_cnt = 0; last_rd = -1; flush_cnt = 0; flush_cyc = -1;
        fl_rise = -1; done_cyc = -1; done_who = -1; data_err = 0; sel_err = 0;
        while (done_cyc < 0 && cyc < 300) begin
            @(posedge CLK);
            #1;
            bus.IN0_DATA          = 32'hA000_0000 + cyc;
            bus.IN1_DATA          = 32'hB000_0000 + cyc;
            bus.DIST_INDATA_RD_EN = ((cyc % rd_period) == (rd_period - 1));
            bus.DIST_FLUSHED      = (flush_cyc >= 0) && (cyc >= flush_cyc + fl_delay);
            if (bus.DIST_FLUSHED && fl_rise < 0) fl_rise = cyc;
            #1;
            if (cyc == 0) first_gnt = {bus.GNT1, bus.GNT0};
            if (bus.GNT0 && gnt0_first < 0) gnt0_first = cyc;
            if (bus.GNT1 && gnt1_first < 0) gnt1_first = cyc;
            if (bus.IN0_RD_EN) begin rd0_cnt++; last_rd = cyc; end
            if (bus.IN1_RD_EN) begin rd1_cnt++; last_rd = cyc; end
            if (bus.DIST_FLUSH) begin
                flush_cnt++;
                if (flush_cyc < 0) flush_cyc = cyc;
            end
            exp_data = exp_sel ? bus.IN1_DATA : bus.IN0_DATA;
            if (bus.DIST_INDATA_EN && bus.DIST_INDATA !== exp_data) data_err++;
            if ((bus.GNT0 || bus.GNT1) && bus.OUT_SEL !== exp_sel) sel_err++;
            if (bus.DONE0 || bus.DONE1) begin
                done_cyc = cyc;
                done_who = bus.DONE1 ? 1 : 0;
            end
            cyc++;
        end
        if (done_cyc < 0) check("xfer_timeout", 64'd0, 64'd1);
        bus.DIST_FLUSHED      = 1'b0;
        bus.DIST_INDATA_RD_EN = 1'b0;
        $display("xfer: req%0d reads=%0d/%0d flush@%0d flushed@%0d done@%0d",
                 done_who, rd0_cnt, rd1_cnt, flush_cyc, fl_rise, done_cyc);
    endtask

    // One XFER cycle of the FWFT-gap test: drive IN0_EN and check the mirror.
    task automatic xstep(input logic en);
        @(posedge CLK);
        #1;
        bus.IN0_EN = en;
        #1;
        check("gap_en_mirror", bus.DIST_INDATA_EN, en);
        check("gap_gnt0", bus.GNT0, 1);
        check("gap_in1_rd", bus.IN1_RD_EN, 0);
        check("gap_no_early_flush", bus.DIST_FLUSH, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hold_err;

        RST_N = 1'b0;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b0;
        bus.LEN0 = 16'd3; bus.LEN1 = 16'd0;
        bus.IN0_EN = 1'b1; bus.IN1_EN = 1'b0;
        bus.IN0_DATA = '0; bus.IN1_DATA = '0;
        bus.DIST_INDATA_RD_EN = 1'b0; bus.DIST_FLUSHED = 1'b0;

        // ---- Reset state (REQ0 already high, must not be granted) ----------
        repeat (2) @(posedge CLK);
        #1;
        check("rst_gnt0", bus.GNT0, 0);
        check("rst_gnt1", bus.GNT1, 0);
        check("rst_done", {bus.DONE1, bus.DONE0}, 0);
        check("rst_rd_en", {bus.IN1_RD_EN, bus.IN0_RD_EN}, 0);
        check("rst_dist_en", bus.DIST_INDATA_EN, 0);
        check("rst_flush", bus.DIST_FLUSH, 0);
        check("rst_out_sel", bus.OUT_SEL, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // ---- LEN0=3, distributor reads every 4th cycle ----------------------
        run_xfer(1'b0, 4, 3);
        check("t1_gnt0_seen", gnt0_first >= 0, 1);
        check("t1_gnt1_never", gnt1_first >= 0, 0);
        check("t1_rd0_pulses", rd0_cnt, 3);
        check("t1_rd1_pulses", rd1_cnt, 0);
        check("t1_flush_count", flush_cnt, 1);
        check("t1_flush_after_3rd", flush_cyc, last_rd + 1);
        check("t1_done_who", done_who, 0);
        check("t1_done_after_flushed", done_cyc, fl_rise + 1);
        check("t1_data", data_err, 0);
        check("t1_out_sel", sel_err, 0);
        bus.REQ0 = 1'b0;
        @(posedge CLK);
        #2;
        check("t1_idle_gnt0", bus.GNT0, 0);

        // ---- Round robin: both requesting from reset ------------------------
        RST_N = 1'b0;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        bus.LEN0 = 16'd2; bus.LEN1 = 16'd2;
        bus.IN0_EN = 1'b1; bus.IN1_EN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        run_xfer(1'b0, 1, 1);
        check("rr1_winner", done_who, 0);
        check("rr1_gnt1_never", gnt1_first >= 0, 0);
        check("rr1_rd0", rd0_cnt, 2);
        bus.REQ0 = 1'b0;
        run_xfer(1'b1, 1, 1);
        check("rr2_idle_gap", first_gnt, 0);
        check("rr2_winner", done_who, 1);
        check("rr2_gnt0_never", gnt0_first >= 0, 0);
        check("rr2_rd1", rd1_cnt, 2);
        check("rr2_rd0", rd0_cnt, 0);
        check("rr2_data", data_err, 0);
        check("rr2_out_sel", sel_err, 0);
        bus.REQ0 = 1'b1;
        run_xfer(1'b0, 1, 1);
        check("rr3_idle_gap", first_gnt, 0);
        check("rr3_winner", done_who, 0);
        check("rr3_gnt1_never", gnt1_first >= 0, 0);

        // ---- LEN1=0: flush in the first grant cycle -------------------------
        bus.REQ0 = 1'b0;
        bus.LEN1 = 16'd0;
        run_xfer(1'b1, 1, 2);
        check("z_gnt1_seen", gnt1_first >= 0, 1);
        check("z_rd1_none", rd1_cnt, 0);
        check("z_flush_first_cycle", flush_cyc, gnt1_first);
        check("z_flush_count", flush_cnt, 1);
        check("z_done_who", done_who, 1);
        check("z_done_after_flushed", done_cyc, fl_rise + 1);
        bus.REQ1 = 1'b0;

        // ---- FWFT valid gaps 1,0,0,1,1 with LEN0=3 --------------------------
        bus.REQ0 = 1'b1; bus.LEN0 = 16'd3;
        bus.IN0_EN = 1'b0; bus.IN1_EN = 1'b1;
        bus.DIST_INDATA_RD_EN = 1'b1;
        @(posedge CLK);                       // DONE -> IDLE
        xstep(1'b1);
        xstep(1'b0);
        xstep(1'b0);
        xstep(1'b1);
        xstep(1'b1);
        @(posedge CLK);
        #1;
        check("gap_flush", bus.DIST_FLUSH, 1);
        check("gap_flush_dist_en", bus.DIST_INDATA_EN, 0);
        check("gap_flush_rd0", bus.IN0_RD_EN, 0);
        bus.DIST_FLUSHED = 1'b1;
        @(posedge CLK);
        #1;
        check("gap_wait_no_done", bus.DONE0, 0);
        @(posedge CLK);
        #1;
        check("gap_done0", bus.DONE0, 1);
        bus.REQ0 = 1'b0; bus.DIST_FLUSHED = 1'b0;
        $display("xfer: req0 fwft-gap transfer finished");
        @(posedge CLK);
        #1;
        check("gap_idle_gnt0", bus.GNT0, 0);

        // ---- Reset asserted during WAIT -------------------------------------
        bus.REQ0 = 1'b1; bus.LEN0 = 16'd1; bus.IN0_EN = 1'b1;
        repeat (3) @(posedge CLK);            // XFER, FLUSH, WAIT
        #1;
        check("rw_wait_gnt0", bus.GNT0, 1);
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b1; bus.LEN1 = 16'd1; bus.IN1_EN = 1'b1;
        RST_N = 1'b0;
        #1;
        check("rw_gnt0_cleared", bus.GNT0, 0);
        check("rw_flush_low", bus.DIST_FLUSH, 0);
        check("rw_no_done0", bus.DONE0, 0);
        check("rw_out_sel", bus.OUT_SEL, 0);
        @(posedge CLK);
        #1;
        check("rw_in_reset_done", {bus.DONE1, bus.DONE0}, 0);
        check("rw_in_reset_gnt1", bus.GNT1, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rw_gnt1_after", bus.GNT1, 1);
        check("rw_gnt0_after", bus.GNT0, 0);
        check("rw_out_sel_after", bus.OUT_SEL, 1);
        bus.DIST_FLUSHED = 1'b1;
        repeat (3) @(posedge CLK);            // FLUSH, WAIT, DONE
        #1;
        check("rw_done1", bus.DONE1, 1);
        check("rw_no_done0_end", bus.DONE0, 0);
        $display("xfer: req1 after reset finished");
        bus.REQ1 = 1'b0; bus.DIST_FLUSHED = 1'b0;
        @(posedge CLK);

        // ---- Long WAIT: DIST_FLUSHED low for 50 cycles ----------------------
        bus.REQ0 = 1'b1; bus.LEN0 = 16'd1; bus.IN0_EN = 1'b1;
        repeat (3) @(posedge CLK);            // XFER, FLUSH, WAIT
        hold_err = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!bus.GNT0 || bus.DONE0 || bus.DIST_FLUSH || bus.DIST_INDATA_EN) hold_err++;
            @(posedge CLK);
        end
        #1;
        check("lw_hold", hold_err, 0);
        check("lw_gnt0", bus.GNT0, 1);
        bus.DIST_FLUSHED = 1'b1;
        #1;
        check("lw_no_done_yet", bus.DONE0, 0);
        @(posedge CLK);
        #1;
        check("lw_done0", bus.DONE0, 1);
        check("lw_gnt0_in_done", bus.GNT0, 1);
        $display("xfer: req0 long-wait transfer finished");
        bus.REQ0 = 1'b0; bus.DIST_FLUSHED = 1'b0;
        @(posedge CLK);
        #1;
        check("lw_done_one_cycle", bus.DONE0, 0);
        check("lw_idle_gnt0", bus.GNT0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_distribute_arbiter
